// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed RAM, one outstanding transaction at a time.
// Supports FIXED/INCR (WRAP handled as INCR) bursts with byte strobes.
module axi_sram_slave #(
  parameter int ADDR_W    = 12,
  parameter int INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  state_t state, state_nx;

  logic [31:0] ax_addr;
  logic [3:0]  ax_len;
  logic [2:0]  ax_size;
  logic        ax_fixed;
  logic [3:0]  cnt;
  logic        wl_err;
  logic [31:0] ram_q;
  logic [31:0] mem [2**ADDR_W] = '{default: ((INIT_ZERO != 0) ? 32'h0 : 32'hx)};

  logic              size_err;
  logic              last_beat;
  logic              ar_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              rd_fetch;
  logic              wl_bad;
  logic [31:0]       next_addr;
  logic [ADDR_W-1:0] widx;

  assign size_err  = ax_size > 3'd2;
  assign last_beat = cnt == ax_len;
  assign next_addr = ax_fixed ? ax_addr : ax_addr + (32'd1 << ax_size);
  assign widx      = ax_addr[ADDR_W+1:2];
  assign aw_hs     = awvalid && awready;
  assign ar_hs     = arvalid && arready;
  assign w_hs      = wvalid && wready;
  assign wl_bad    = wlast != last_beat;
  // Fetch the next beat whenever the output slot is empty or being drained,
  // except after the last beat has been fetched.
  assign rd_fetch  = (state == RD) && !(rvalid && (!rready || rlast));
  assign rdata     = rvalid ? ram_q : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    arready  = 1'b0;
    awready  = 1'b0;
    wready   = 1'b0;
    case (state)
      IDLE: begin
        awready = resetn;
        arready = resetn && !awvalid;
        if (awvalid)      state_nx = WR;
        else if (arvalid) state_nx = RD;
      end
      RD: begin
        if (rvalid && rready && rlast) state_nx = IDLE;
      end
      WR: begin
        wready = 1'b1;
        if (wvalid && last_beat) state_nx = WRESP;
      end
      WRESP: begin
        if (bready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ax_addr  <= '0;
      ax_len   <= '0;
      ax_size  <= '0;
      ax_fixed <= 1'b0;
      cnt      <= '0;
      wl_err   <= 1'b0;
      rid      <= '0;
      rresp    <= '0;
      rlast    <= 1'b0;
      rvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= '0;
      bvalid   <= 1'b0;
    end else begin
      if (aw_hs) begin
        bid      <= awid;
        ax_addr  <= awaddr;
        ax_len   <= awlen;
        ax_size  <= awsize;
        ax_fixed <= awburst == 2'b00;
        cnt      <= '0;
        wl_err   <= 1'b0;
      end else if (ar_hs) begin
        rid      <= arid;
        ax_addr  <= araddr;
        ax_len   <= arlen;
        ax_size  <= arsize;
        ax_fixed <= arburst == 2'b00;
        cnt      <= '0;
      end

      if (rd_fetch) begin
        ax_addr <= next_addr;
        cnt     <= cnt + 4'd1;
        rvalid  <= 1'b1;
        rlast   <= last_beat;
        rresp   <= size_err ? 2'b10 : 2'b00;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end

      if (w_hs) begin
        ax_addr <= next_addr;
        cnt     <= cnt + 4'd1;
        wl_err  <= wl_err | wl_bad;
        if (last_beat) begin
          bvalid <= 1'b1;
          bresp  <= (size_err || wl_err || wl_bad) ? 2'b10 : 2'b00;
        end
      end

      if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !size_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (rd_fetch) ram_q <= size_err ? '0 : mem[widx];
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: drivers queue expected R/B responses,
// a negedge monitor pops and compares on every handshake.
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  axi_sram_slave #(.ADDR_W(12), .INIT_ZERO(1)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t exp_r[$];
  bexp_t exp_b[$];

  int checks = 0;
  int passed = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];
  logic [31:0] rd_exp [16];
  logic [5:0]  pat = 6'b101101;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every R/B handshake against the queues and checks stall stability.
  logic        prev_stall = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;

  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("r_hold_valid", 32'(rvalid), 32'd1);
        check("r_hold_data", rdata, hold_data);
        check("r_hold_last", 32'(rlast), 32'(hold_last));
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          check("r_unexpected", 32'(rvalid), 32'd0);
        end else begin
          rexp_t e;
          e = exp_r.pop_front();
          check("r_data", rdata, e.data);
          check("r_id_resp_last", 32'({rid, rresp, rlast}), 32'({e.id, e.resp, e.last}));
        end
      end
      prev_stall = rvalid && !rready;
      hold_data  = rdata;
      hold_last  = rlast;
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected", 32'(bvalid), 32'd0);
        end else begin
          bexp_t e;
          e = exp_b.pop_front();
          check("b_id_resp", 32'({bid, bresp}), 32'({e.id, e.resp}));
        end
      end
    end
  end

  task automatic set_beat(input int b, input logic [31:0] d, input logic [3:0] s, input logic l);
    wd[b] = d;
    ws[b] = s;
    wl[b] = l;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp);
    int t;
    exp_b.push_back('{id, exp_resp});
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!awready && t < 50) begin @(negedge clk); t++; end
    check("aw_accept", 32'(awready), 32'd1);
    if (arvalid) check("ar_blocked_by_aw", 32'(arready), 32'd0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = wl[b];
      t = 0;
      @(negedge clk);
      while (!wready && t < 50) begin @(negedge clk); t++; end
      check("w_accept", 32'(wready), 32'd1);
      if (b == 0) check("busy_no_addr_ready", 32'({arready, awready}), 32'd0);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    check("b_arrive", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // mode 0: rready held high with latency check; 1: toggled pattern; 2: reset after two beats
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp,
                         input int mode);
    int t;
    int got;
    int c;
    for (int b = 0; b <= int'(len); b++) exp_r.push_back('{id, rd_exp[b], resp, b == int'(len)});
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arready && t < 50) begin @(negedge clk); t++; end
    check("ar_accept", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    got = 0;
    c = 0;
    while (got <= int'(len) && c < 100) begin
      rready = (mode == 1) ? pat[c % 6] : 1'b1;
      @(negedge clk);
      if (mode == 0 && c == 0) check("lat_t1_rvalid", 32'(rvalid), 32'd0);
      if (mode == 0 && c == 1) check("lat_t2_rvalid", 32'(rvalid), 32'd1);
      if (rvalid && rready) got++;
      @(posedge clk); #1;
      if (mode == 2 && got == 2) begin
        resetn = 1'b0;
        rready = 1'b0;
        #1;
        check("rst_rvalid_async", 32'({rvalid, rlast}), 32'd0);
        check("rst_addr_ready", 32'({arready, awready}), 32'd0);
        exp_r.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        return;
      end
      c++;
    end
    rready = 1'b0;
    check("r_all_beats", got, 32'(int'(len) + 1));
    @(negedge clk);
    check("r_done_rvalid", 32'(rvalid), 32'd0);
    check("r_done_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_readies", 32'({arready, awready, wready}), 32'd0);
    check("rst_valids", 32'({rvalid, rlast, bvalid}), 32'd0);
    check("rst_ids_resps", 32'({rid, bid, rresp, bresp}), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("idle_readies", 32'({arready, awready}), 32'b11);
    @(posedge clk); #1;

    // single write then read-back with T+2 latency
    set_beat(0, 32'hDEADBEEF, 4'hF, 1'b1);
    do_write(4'd3, 32'h10, 4'd0, 3'd2, 2'b01, 2'b00);
    rd_exp[0] = 32'hDEADBEEF;
    do_read(4'd5, 32'h10, 4'd0, 3'd2, 2'b01, 2'b00, 0);

    // byte strobes
    set_beat(0, 32'hAABBCCDD, 4'hF, 1'b1);
    do_write(4'd1, 32'h14, 4'd0, 3'd2, 2'b01, 2'b00);
    set_beat(0, 32'h11223344, 4'b0101, 1'b1);
    do_write(4'd2, 32'h14, 4'd0, 3'd2, 2'b01, 2'b00);
    rd_exp[0] = 32'hAA22CC44;
    do_read(4'd4, 32'h14, 4'd0, 3'd2, 2'b01, 2'b00, 0);

    // INCR burst write, then stalled INCR read
    for (int b = 0; b < 4; b++) set_beat(b, 32'h1111_00A0 + 32'(b), 4'hF, b == 3);
    do_write(4'd6, 32'h20, 4'd3, 3'd2, 2'b01, 2'b00);
    for (int b = 0; b < 4; b++) rd_exp[b] = 32'h1111_00A0 + 32'(b);
    do_read(4'd7, 32'h20, 4'd3, 3'd2, 2'b01, 2'b00, 1);

    // byte-sized INCR read stays within word 0x20
    for (int b = 0; b < 4; b++) rd_exp[b] = 32'h1111_00A0;
    do_read(4'd8, 32'h20, 4'd3, 3'd0, 2'b01, 2'b00, 0);

    // upper address bits alias
    rd_exp[0] = 32'hDEADBEEF;
    do_read(4'd9, 32'h4000_0010, 4'd0, 3'd2, 2'b01, 2'b00, 0);

    // simultaneous AW/AR: write goes first, read sees the new data
    arid = 4'd2; araddr = 32'h30; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    set_beat(0, 32'hCAFEF00D, 4'hF, 1'b1);
    do_write(4'd1, 32'h30, 4'd0, 3'd2, 2'b01, 2'b00);
    rd_exp[0] = 32'hCAFEF00D;
    do_read(4'd2, 32'h30, 4'd0, 3'd2, 2'b01, 2'b00, 0);

    // FIXED burst with early wlast: last data lands, SLVERR
    set_beat(0, 32'd1, 4'hF, 1'b0);
    set_beat(1, 32'd2, 4'hF, 1'b1);
    set_beat(2, 32'd3, 4'hF, 1'b0);
    do_write(4'hA, 32'h40, 4'd2, 3'd2, 2'b00, 2'b10);
    rd_exp[0] = 32'd3;
    do_read(4'hB, 32'h40, 4'd0, 3'd2, 2'b01, 2'b00, 0);

    // oversize write suppressed, oversize read returns zero with SLVERR
    set_beat(0, 32'hFFFF_FFFF, 4'hF, 1'b1);
    do_write(4'hB, 32'h40, 4'd0, 3'd3, 2'b01, 2'b10);
    rd_exp[0] = 32'd3;
    do_read(4'hC, 32'h40, 4'd0, 3'd2, 2'b01, 2'b00, 0);
    rd_exp[0] = 32'd0;
    do_read(4'hD, 32'h40, 4'd0, 3'd3, 2'b01, 2'b10, 0);

    // INCR past the RAM top wraps to word 0
    set_beat(0, 32'h0000_0055, 4'hF, 1'b0);
    set_beat(1, 32'h0000_0066, 4'hF, 1'b1);
    do_write(4'hC, 32'h3FFC, 4'd1, 3'd2, 2'b01, 2'b00);
    rd_exp[0] = 32'h0000_0066;
    do_read(4'h1, 32'h0, 4'd0, 3'd2, 2'b01, 2'b00, 0);
    rd_exp[0] = 32'h0000_0055;
    do_read(4'h2, 32'h3FFC, 4'd0, 3'd2, 2'b01, 2'b00, 0);

    // reset in the middle of a read burst; RAM survives
    for (int b = 0; b < 4; b++) rd_exp[b] = 32'h1111_00A0 + 32'(b);
    do_read(4'hE, 32'h20, 4'd3, 3'd2, 2'b01, 2'b00, 2);
    @(negedge clk);
    check("post_rst_idle", 32'({arready, awready, rvalid, bvalid}), 32'b1100);
    @(posedge clk); #1;
    do_read(4'hF, 32'h20, 4'd3, 3'd2, 2'b01, 2'b00, 0);
    rd_exp[0] = 32'hAA22CC44;
    do_read(4'h3, 32'h14, 4'd0, 3'd2, 2'b01, 2'b00, 0);

    repeat (3) @(posedge clk);
    check("r_queue_drained", exp_r.size(), 32'd0);
    check("b_queue_drained", exp_b.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
